muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//   Iterative RV32M multiply/divide sequencer beside the single-cycle ALU in EX.
//   Accepts one M-op via a valid/ready handshake and runs a radix-2 shift-add
//   (MUL*) or restoring shift-subtract (DIV*/REM*) loop, one bit per cycle.
//   Applies sign fix-up and returns the 32-bit result via valid/ready.
//   The pipeline stalls EX while in_ready is low or the result is outstanding.
// PARAMETERS
//   XLEN     32   operand/result width; iteration count equals XLEN
// PORTS
//   clk         in   1     clock; all state changes on rising edge
//   rst         in   1     synchronous, active-high reset
//   in_valid    in   1     request valid
//   in_ready    out  1     unit can accept (high only in IDLE)
//   in_op       in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   in_a        in   XLEN  rs1 operand (multiplicand / dividend)
//   in_b        in   XLEN  rs2 operand (multiplier / divisor)
//   flush       in   1     abort current op (branch mispredict / trap)
//   out_valid   out  1     result valid
//   out_ready   in   1     consumer takes result
//   out_result  out  XLEN  result
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE, out_valid=0, out_result=0, counter=0; in_ready=1
//     after. Overrides flush and any handshake in that cycle.
//   States: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: in_ready=1. in_valid at edge latches op/operands; goes CALC, counter=XLEN-1.
//     Signed ops latch |a|, |b| plus result-sign flags (MULHSU: a signed, b unsigned).
//   CALC: one iteration/cycle, exactly XLEN cycles; counter decrements, at 0 -> FIX.
//     Multiply: 2*XLEN-bit unsigned product accumulator. Divide: XLEN+1-bit partial
//     remainder; subtract, keep when non-negative, shift quotient bit in.
//   FIX: negate product/quotient/remainder per sign flags (rem sign = dividend sign);
//     selects low word (MUL) or high word (MULH*); registers out_result; -> DONE.
//   DONE: out_valid=1, out_result stable until out_valid&out_ready at an edge, then
//     out_valid=0, IDLE. No new request accepted in that same edge (in_ready low in DONE).
//   Latency: accept at edge 0 -> out_valid high from edge XLEN+2 (34 for XLEN=32).
//   Special cases (RISC-V defined, no trap):
//     divide by zero: DIV/DIVU quotient = all ones; REM/REMU remainder = in_a.
//     signed overflow (in_a=0x80000000, in_b=-1): DIV = 0x80000000, REM = 0.
//   flush: any non-IDLE state -> IDLE next edge, out_valid=0, result discarded;
//     in IDLE, flush blocks acceptance that edge (in_ready still reads 1).
//   Operand values on in_* ignored outside the accepting edge.
// CONFIGURATION
//   MULDIV_EARLY_OUT_EN defined: div-by-zero and signed-overflow cases detected in
//     IDLE; accept -> DONE directly, out_valid from edge 1 with the special result.
//   Undefined: special cases run full CALC/FIX path, latency XLEN+2; identical results
//     come from the normal datapath plus FIX overrides.
// TESTING
//   MUL a=7, b=-3 (0xFFFFFFFD) -> 0xFFFFFFEB; out_valid at edge 34; in_ready low edges 1..34.
//   MULH a=0x80000000,b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE;
//     MULHSU a=-1,b=0xFFFFFFFF -> 0xFFFFFFFF.
//   DIV a=-7,b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
//   DIVU a=5,b=0 -> 0xFFFFFFFF; REM a=5,b=0 -> 5; DIV 0x80000000/-1 -> 0x80000000, REM -> 0;
//     latency 1 edge with MULDIV_EARLY_OUT_EN, 34 without.
//   Hold out_ready=0 for 10 cycles in DONE -> out_valid/out_result stable; release -> IDLE.
//   flush at edge 10 of a DIV, and rst at edge 20 of a MUL -> IDLE next edge, out_valid never
//     asserted; back-to-back next op gives correct result.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq -- iterative RV32M multiply/divide unit that sits beside the
// single-cycle ALU in EX. It takes one M-extension op at a time and produces
// one result bit per cycle, then applies the sign fix-up.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   in_valid / in_ready   request handshake; in_op = funct3
//                         (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU,
//                          4 DIV, 5 DIVU, 6 REM, 7 REMU)
//   in_a, in_b            rs1 / rs2 operands, sampled only on the accepting edge
//   flush                 abort the op in flight; blocks acceptance while idle
//   out_valid / out_ready result handshake; out_result holds the result
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE. out_valid is high only in DONE,
// and out_result stays constant until the transfer edge.
//
// Optional build macro
//   MULDIV_EARLY_OUT_EN  divide-by-zero and signed divide overflow are
//                        recognised at acceptance and answered from DONE
//                        one edge later, skipping the iterative loop.
//
// The FSM state is held in the internal signal 'state' (IDLE/CALC/FIX/DONE).
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]     count;
  logic [2:0]        op_q;
  logic              neg_q;      // product / quotient must be negated
  logic              rem_neg_q;  // remainder takes the dividend's sign
  logic              bzero_q;    // divisor was zero
  logic [XLEN-1:0]   opd;        // multiplicand (mul) or divisor (div), magnitude
  logic [2*XLEN-1:0] acc;        // mul: {hi, multiplier/lo}; div: low half = dividend -> quotient
  logic [XLEN-1:0]   rem;        // partial remainder

  // ---------------- acceptance decode ----------------
  logic            a_signed, b_signed, a_neg, b_neg, accept, early_out;
  logic [XLEN-1:0] a_abs, b_abs;

  assign a_signed = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6);
  assign b_signed = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
  assign a_neg    = a_signed & in_a[XLEN-1];
  assign b_neg    = b_signed & in_b[XLEN-1];
  assign a_abs    = a_neg ? -in_a : in_a;
  assign b_abs    = b_neg ? -in_b : in_b;
  assign accept   = (state == IDLE) && in_valid && !flush;

`ifdef MULDIV_EARLY_OUT_EN
  logic [XLEN-1:0] special_result;
  logic            ovf;
  // Signed overflow only exists for DIV/REM (funct3 bit0 clear).
  assign ovf       = !in_op[0] && (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (&in_b);
  assign early_out = in_op[2] && ((in_b == '0) || ovf);
  // b == 0: quotient all ones, remainder = dividend.
  // overflow: quotient = dividend (most negative value), remainder = 0.
  assign special_result = (in_b == '0) ? (in_op[1] ? in_a : '1)
                                       : (in_op[1] ? '0 : in_a);
`else
  assign early_out = 1'b0;
`endif

  // ---------------- one iteration of each loop ----------------
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] acc_mul_next;

  // Shift-add: add the multiplicand into the high half when the current
  // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
  assign mul_sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
  assign acc_mul_next = {mul_sum, acc[XLEN-1:1]};

  // Restoring divide: bring in the next dividend bit, trial-subtract the
  // divisor; a clear sign bit means the subtraction is kept.
  assign div_shift = {rem, acc[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opd};

  // ---------------- sign fix-up ----------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   mul_res, div_q, div_r, fix_result;

  assign prod_fix   = neg_q ? -acc : acc;
  assign mul_res    = (op_q == 3'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  // The unsigned loop already yields all ones for x/0; only the sign flip
  // must be suppressed so a negative dividend does not turn it into +1.
  assign div_q      = bzero_q ? '1 : (neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
  assign div_r      = rem_neg_q ? -rem : rem;
  assign fix_result = op_q[2] ? (op_q[1] ? div_r : div_q) : mul_res;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = early_out ? DONE : CALC;
      CALC: if (count == '0) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      bzero_q    <= 1'b0;
      opd        <= '0;
      acc        <= '0;
      rem        <= '0;
      out_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            count     <= CW'(XLEN - 1);
            op_q      <= in_op;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            bzero_q   <= (in_b == '0);
            rem       <= '0;
            if (in_op[2]) begin
              opd <= b_abs;
              acc <= {{XLEN{1'b0}}, a_abs};
            end else begin
              opd <= a_abs;
              acc <= {{XLEN{1'b0}}, b_abs};
            end
`ifdef MULDIV_EARLY_OUT_EN
            if (early_out) out_result <= special_result;
`endif
          end
        end
        CALC: begin
          count <= count - 1'b1;
          if (op_q[2]) begin
            acc <= {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], ~div_diff[XLEN]};
            rem <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
          end else begin
            acc <= acc_mul_next;
          end
        end
        FIX:  out_result <= fix_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq. Inputs are driven on the falling edge
// and outputs are sampled there too, so the value seen at a falling edge is
// the value the next rising edge will see. Edge numbering follows the
// accepting edge = edge 0.
module tb_muldiv_seq;

  localparam int XLEN     = 32;
  localparam int NORM_LAT = XLEN + 2;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = NORM_LAT;
`endif

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  logic            clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [2:0]      in_op;
  logic [XLEN-1:0] in_a, in_b, out_result;

  int checks   = 0;
  int failures = 0;
  logic [XLEN-1:0] exp_q[$];

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Cases the early-out build answers without running the loop.
  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // ---------------- drivers ----------------
  // Called just after a falling edge; returns one falling edge after the
  // accepting rising edge, with junk on the operand inputs.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_op    = 3'($urandom_range(0, 7));
    in_a     = $urandom;
    in_b     = $urandom;
  endtask

  // Counts edges (edge 1 = first after acceptance) until out_valid is seen,
  // and notes whether in_ready ever rose while waiting.
  task automatic wait_valid(output int lat, output bit busy_ok);
    lat     = 1;
    busy_ok = 1'b1;
    while (lat <= 200) begin
      if (in_ready) busy_ok = 1'b0;
      if (out_valid) break;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int hold);
    int           lat;
    bit           busy_ok, stable;
    logic [31:0]  got;
    check_eq({tag, "_idle"}, 32'(in_ready), 32'd1);
    exp_q.push_back(exp);
    out_ready = (hold == 0);
    issue(op, a, b);
    wait_valid(lat, busy_ok);
    check_eq({tag, "_lat"}, 32'(lat), 32'(is_special(op, a, b) ? SPEC_LAT : NORM_LAT));
    check_eq({tag, "_busy"}, 32'(busy_ok), 32'd1);
    got = out_result;
    check_eq({tag, "_res"}, got, exp_q.pop_front());
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!out_valid || out_result !== got) stable = 1'b0;
      end
      check_eq({tag, "_hold"}, 32'(stable), 32'd1);
      out_ready = 1'b1;
    end
    @(negedge clk);
    check_eq({tag, "_ret"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  // Starts an op and aborts it at the given edge with flush or rst.
  task automatic abort_op(input string tag, input bit use_rst, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int at_edge);
    bit seen = 1'b0;
    out_ready = 1'b1;
    issue(op, a, b);
    repeat (at_edge - 1) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    if (use_rst) rst = 1'b1;
    else         flush = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    flush = 1'b0;
    check_eq({tag, "_idle"}, 32'({out_valid, in_ready}), 32'b01);
    if (use_rst) check_eq({tag, "_rst_res"}, out_result, 32'h0);
    repeat (NORM_LAT + 4) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    check_eq({tag, "_no_valid"}, 32'(seen), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_op = '0; in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("reset_in_ready",  32'(in_ready),  32'd1);
    check_eq("reset_out_valid", 32'(out_valid), 32'd0);
    check_eq("reset_result",    out_result,     32'h0);

    // Multiply family
    do_op("mul",      OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    do_op("mul_lo",   OP_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 0);
    do_op("mulh",     OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    do_op("mulhu",    OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    do_op("mulhu_sm", OP_MULHU,  32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 0);
    do_op("mulhsu",   OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    // Divide family
    do_op("div",      OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0);
    do_op("rem",      OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
    do_op("div_nb",   OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 0);
    do_op("rem_nb",   OP_REM,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 0);
    do_op("divu",     OP_DIVU,   32'd100,       32'd7,         32'd14,        0);
    do_op("remu",     OP_REMU,   32'd100,       32'd7,         32'd2,         0);

    // Special cases
    do_op("divu_z",   OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 0);
    do_op("remu_z",   OP_REMU,   32'd5,         32'd0,         32'd5,         0);
    do_op("div_z",    OP_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 0);
    do_op("rem_z",    OP_REM,    32'd5,         32'd0,         32'd5,         0);
    do_op("rem_zn",   OP_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 0);
    do_op("div_ovf",  OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    do_op("rem_ovf",  OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    do_op("divu_big", OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);

    // Back-pressure in DONE
    do_op("hold",     OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 10);

    // Flush while idle blocks acceptance but in_ready still reads 1
    in_op = OP_DIVU; in_a = 32'd100; in_b = 32'd7;
    in_valid = 1'b1; flush = 1'b1;
    check_eq("idle_flush_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check_eq("idle_flush_block", 32'({out_valid, in_ready}), 32'b01);

    // Aborts followed by a back-to-back op
    abort_op("flush_div", 1'b0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 10);
    do_op("after_flush", OP_DIVU, 32'd100, 32'd7, 32'd14, 0);
    abort_op("rst_mul", 1'b1, OP_MUL, 32'd7, 32'hFFFF_FFFD, 20);
    do_op("after_rst", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
